sram_loader: RTL and testbench
==============================

# sram_loader

Boot-time loader between the UART receive byte stream and the four-lane instruction/data SRAM macros. It parses a simple framed byte protocol and packs bytes into 32-bit words. Each word is written in one cycle across all four byte lanes of the selected memory. The core is held in reset until a GO command arrives. It replaces bench-side memory initialisation with an in-silicon path and owns the SRAM pins while `load_active` is high.

## Interface
- `MEM_WORDS`, 512: words per memory; valid address range 0..MEM_WORDS-1.
- `ADDR_W`, 9: SRAM address width, equal to clog2(MEM_WORDS).

- `clk`: input, 1 bit. Single clock; all state changes on its rising edge.
- `rst`: input, 1 bit. Asynchronous, active-low reset.
- `in_valid`: input, 1 bit. Byte available from the UART receiver.
- `in_data`: input, 8 bits. Received byte.
- `in_ready`: output, 1 bit. Loader accepts the byte. A transfer occurs when `in_valid` and `in_ready` are both high at a clock edge.
- `CEN_imem[0:3]`, `GWEN_imem[0:3]`: output, 1 bit per lane. Active-low chip enable and global write enable for each imem lane.
- `WEN_imem[0:3]`: output, 8 bits per lane. Active-low bit write enables.
- `A_imem[0:3]`: output, ADDR_W bits per lane. Word address.
- `D_imem[0:3]`: output, 8 bits per lane. Write data.
- `CEN_dmem`, `GWEN_dmem`, `WEN_dmem`, `A_dmem`, `D_dmem`: same shapes and meanings as the imem signals, for dmem.
- `core_rst`: output, 1 bit. Active-high reset to the core.
- `load_active`: output, 1 bit. Steers the SRAM mux to the loader when high.
- `err`: output, 1 bit. Sticky protocol error flag.

## Operation
- Frame format: a command byte, then length LO, then length HI (little-endian word count N), then 4·N data bytes. Byte k of each word goes to lane k, lane 0 first.
- Command bytes:
  - 0x49 'I' targets imem.
  - 0x44 'D' targets dmem.
  - 0x47 'G' releases the core and takes no length bytes.
  - 0x52 'R' is accepted only in RUN and returns the loader to IDLE.
  - Any other byte in IDLE is consumed and ignored.
- States:
  - IDLE: on 'I' or 'D', latch the target and go to LEN_LO. On 'G', go to RUN.
  - LEN_LO: latch the low length byte, then go to LEN_HI.
  - LEN_HI: if N is 0 or greater than MEM_WORDS, set `err` and go to IDLE. Otherwise clear the word index and go to DATA.
  - DATA: shift in 4 bytes, then go to WRITE.
  - WRITE: one cycle. Then go to DATA if word index+1 < N, else go to IDLE. The word index increments in either case.
  - RUN: `core_rst`=0 and `load_active`=0. Accepted 'R' sets `core_rst`=1 and `load_active`=1 and goes to IDLE. All other bytes are discarded.
- Writes always start at address 0 and are sequential. The word index is ADDR_W+1 bits wide, so N=512 ends at index 512 without wrapping.
- In WRITE, the target memory's lanes are driven with CEN=0, GWEN=0, WEN=8'h00, A=word index, D=packed byte k. The other memory stays idle.
- Idle lane values for both memories in every non-WRITE cycle: CEN=1, GWEN=1, WEN=8'hFF, A=0, D=0.
- `err` is set by an invalid length and cleared by the next accepted 'I' or 'D' byte.
- A second 'I'/'D' frame to the same memory overwrites it from address 0.

## Timing
- Reset values while `rst`=0: state IDLE, `in_ready`=0, `core_rst`=1, `load_active`=1, `err`=0. All SRAM lanes are at their idle values and the word index is 0.
- `in_ready`:
  - 1 in IDLE, LEN_LO, LEN_HI, DATA and RUN.
  - 0 in WRITE.
  - 0 during the first cycle after reset deassertion.
- Each accepted byte advances the state at that edge. There is no lookahead.
- Latency: the 4th data byte is accepted at edge t. The SRAM lanes are driven during cycle t..t+1, and the macro samples them at edge t+1. The next byte can be accepted at edge t+2.
- Peak rate: 4 bytes per 5 cycles.
- Reset asserted mid-frame aborts immediately. The partial word is discarded, and the lanes return to idle values asynchronously.
- `core_rst` and `load_active` change on the edge that accepts 'G' or 'R'.

## Structure
- `loader_pkg` holds:
  - The state enum `loader_state_e` (IDLE, LEN_LO, LEN_HI, DATA, WRITE, RUN).
  - The command constants CMD_IMEM, CMD_DMEM, CMD_GO, CMD_RESET.
  - MEM_WORDS.
- One sub-module, `word_packer`: a 4-byte shift register with a byte count. It has inputs for byte valid, byte data and clear, and outputs `word_full` and lanes [0:3]. The FSM, length and index registers and lane drive logic live in `sram_loader`.

## Test plan
- Frame 'I', 02 00, then 13 00 00 00 93 00 10 00: imem lane0 gets 0x13@A0 and 0x93@A1, lane2 gets 0x10@A1, and each write is a single cycle with WEN=0. dmem CEN stays 1 throughout.
- Frame 'D' with N=512 and byte value = index mod 256: 512 dmem writes, the last at A=511, then return to IDLE. There is no write at A=0 after the last word.
- Length 00 00, and length 01 02 (N=513): `err`=1 after the HI byte, no SRAM write, state IDLE. A following valid 'I' frame clears `err`.
- Load 'I' and 'D', then 'G': `core_rst` and `load_active` fall on the edge that accepts 'G'. A later byte 0x00 changes nothing. 'R' re-asserts both.
- `in_valid` held high continuously through a 3-word frame: `in_ready` is low exactly in each WRITE cycle, and no bytes are dropped or duplicated.
- `rst` pulled low after 2 data bytes of word 1: outputs return to reset values with no write issued. After release, a fresh frame loads correctly from A=0.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: shared constants, command bytes and FSM states for the SRAM boot loader
package loader_pkg;
  localparam int MEM_WORDS = 512;
  localparam int ADDR_W = $clog2(MEM_WORDS);
  localparam logic [7:0] CMD_IMEM = 8'h49;
  localparam logic [7:0] CMD_DMEM = 8'h44;
  localparam logic [7:0] CMD_GO = 8'h47;
  localparam logic [7:0] CMD_RESET = 8'h52;
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, RUN} loader_state_e;
endpackage

// File: rtl/sram_loader_word_packer.sv
// word_packer: shifts received bytes into a 4-lane word, first byte ending up in lane 0
module word_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  input  logic       clr,
  output logic       word_full,
  output logic [7:0] lanes [0:3]
);
  logic [1:0] cnt;
  assign word_full = valid && cnt == 2'd3;
  // byte counter wraps after the 4th byte, so the next word starts clean without a clear
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      for (int k = 0; k < 4; k++) lanes[k] <= '0;
    end else if (clr) cnt <= '0;
    else if (valid) begin
      cnt <= cnt + 2'd1;
      for (int k = 0; k < 3; k++) lanes[k] <= lanes[k + 1];
      lanes[3] <= data;
    end
endmodule

// File: rtl/sram_loader.sv
// sram_loader: parses the framed UART byte stream and writes packed words into imem/dmem
module sram_loader
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              CEN_imem  [0:3],
  output logic              GWEN_imem [0:3],
  output logic [7:0]        WEN_imem  [0:3],
  output logic [ADDR_W-1:0] A_imem    [0:3],
  output logic [7:0]        D_imem    [0:3],
  output logic              CEN_dmem  [0:3],
  output logic              GWEN_dmem [0:3],
  output logic [7:0]        WEN_dmem  [0:3],
  output logic [ADDR_W-1:0] A_dmem    [0:3],
  output logic [7:0]        D_dmem    [0:3],
  output logic              core_rst,
  output logic              load_active,
  output logic              err
);
  localparam logic [15:0] MAX_LEN = 16'(MEM_WORDS);
  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);
  loader_state_e state;
  logic tgt;
  logic [7:0] len_lo;
  logic [15:0] len;
  logic [ADDR_W:0] n, idx, idx_nxt;
  logic acc, pk_valid, pk_full, wr_i, wr_d;
  logic [7:0] lanes [0:3];
  assign acc = in_valid && in_ready;
  assign pk_valid = acc && state == DATA;
  assign len = {in_data, len_lo};
  assign idx_nxt = idx + ONE;
  assign wr_i = state == WRITE && !tgt;
  assign wr_d = state == WRITE && tgt;
  word_packer u_packer (
    .clk(clk),
    .rst(rst),
    .valid(pk_valid),
    .data(in_data),
    .clr(acc && state == LEN_HI),
    .word_full(pk_full),
    .lanes(lanes)
  );
  // frame parser; in_ready is registered low only for the single WRITE cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      in_ready <= 1'b0;
      core_rst <= 1'b1;
      load_active <= 1'b1;
      err <= 1'b0;
      tgt <= 1'b0;
      len_lo <= '0;
      n <= '0;
      idx <= '0;
    end else begin
      in_ready <= !(pk_valid && pk_full);
      case (state)
        IDLE:
          if (acc) begin
            if (in_data == CMD_IMEM || in_data == CMD_DMEM) begin
              tgt <= in_data == CMD_DMEM;
              err <= 1'b0;
              state <= LEN_LO;
            end else if (in_data == CMD_GO) begin
              core_rst <= 1'b0;
              load_active <= 1'b0;
              state <= RUN;
            end
          end
        LEN_LO:
          if (acc) begin
            len_lo <= in_data;
            state <= LEN_HI;
          end
        LEN_HI:
          if (acc) begin
            if (len == '0 || len > MAX_LEN) begin
              err <= 1'b1;
              state <= IDLE;
            end else begin
              n <= len[ADDR_W:0];
              idx <= '0;
              state <= DATA;
            end
          end
        DATA: if (pk_valid && pk_full) state <= WRITE;
        WRITE: begin
          idx <= idx_nxt;
          state <= idx_nxt < n ? DATA : IDLE;
        end
        RUN:
          if (acc && in_data == CMD_RESET) begin
            core_rst <= 1'b1;
            load_active <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  // lanes of the target memory are active only in WRITE; everything else sits at idle values
  always_comb
    for (int k = 0; k < 4; k++) begin
      CEN_imem[k] = !wr_i;
      GWEN_imem[k] = !wr_i;
      WEN_imem[k] = wr_i ? 8'h00 : 8'hFF;
      A_imem[k] = wr_i ? idx[ADDR_W-1:0] : '0;
      D_imem[k] = wr_i ? lanes[k] : '0;
      CEN_dmem[k] = !wr_d;
      GWEN_dmem[k] = !wr_d;
      WEN_dmem[k] = wr_d ? 8'h00 : 8'hFF;
      A_dmem[k] = wr_d ? idx[ADDR_W-1:0] : '0;
      D_dmem[k] = wr_d ? lanes[k] : '0;
    end
endmodule

// File: tb/tb_sram_loader.sv
// tb_sram_loader: table-driven and directed checks of the SRAM boot loader
module tb_sram_loader;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, core_rst, load_active, err;
  logic [7:0] in_data;
  logic CEN_imem [0:3], GWEN_imem [0:3], CEN_dmem [0:3], GWEN_dmem [0:3];
  logic [7:0] WEN_imem [0:3], D_imem [0:3], WEN_dmem [0:3], D_dmem [0:3];
  logic [8:0] A_imem [0:3], A_dmem [0:3];

  typedef struct { logic [7:0] b; logic [2:0] f; } vec_t;
  typedef struct { logic d; logic [8:0] a; logic [31:0] w; } wr_t;
  localparam int NV = 36;
  vec_t vt [NV];
  wr_t log_q[$], exp_q[$];
  int tests = 0, fails = 0;
  bit ready_chk = 0;
  logic prev_wr = 1'b0;

  sram_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .CEN_imem(CEN_imem), .GWEN_imem(GWEN_imem), .WEN_imem(WEN_imem), .A_imem(A_imem), .D_imem(D_imem),
    .CEN_dmem(CEN_dmem), .GWEN_dmem(GWEN_dmem), .WEN_dmem(WEN_dmem), .A_dmem(A_dmem), .D_dmem(D_dmem),
    .core_rst(core_rst), .load_active(load_active), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // lane-level checks every cycle: idle values, one-cycle full-width writes, in_ready low only in WRITE
  always @(negedge clk) begin
    logic wi, wd, bad;
    wi = !CEN_imem[0];
    wd = !CEN_dmem[0];
    bad = (wi && wd) || ((wi || wd) && prev_wr);
    for (int k = 0; k < 4; k++) begin
      if (wi) bad |= CEN_imem[k] || GWEN_imem[k] || WEN_imem[k] != 8'h00 || A_imem[k] != A_imem[0];
      else bad |= !CEN_imem[k] || !GWEN_imem[k] || WEN_imem[k] != 8'hFF || A_imem[k] != 0 || D_imem[k] != 0;
      if (wd) bad |= CEN_dmem[k] || GWEN_dmem[k] || WEN_dmem[k] != 8'h00 || A_dmem[k] != A_dmem[0];
      else bad |= !CEN_dmem[k] || !GWEN_dmem[k] || WEN_dmem[k] != 8'hFF || A_dmem[k] != 0 || D_dmem[k] != 0;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL lanes at %0t: got inconsistent lane drive, expected idle or single-cycle write", $time);
    end
    if (wi) log_q.push_back('{1'b0, A_imem[0], {D_imem[3], D_imem[2], D_imem[1], D_imem[0]}});
    if (wd) log_q.push_back('{1'b1, A_dmem[0], {D_dmem[3], D_dmem[2], D_dmem[1], D_dmem[0]}});
    prev_wr = wi || wd;
    if (ready_chk) check("ready_vs_write", in_ready, !(wi || wd));
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 for byte %h", b);
    end else @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pause(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_log();
    check("write_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("write%0d", i), {log_q[i].d, log_q[i].a, log_q[i].w}, {exp_q[i].d, exp_q[i].a, exp_q[i].w});
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: got no finish expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    vt = '{
      '{8'h49, 3'b011}, '{8'h02, 3'b011}, '{8'h00, 3'b011},
      '{8'h13, 3'b011}, '{8'h00, 3'b011}, '{8'h00, 3'b011}, '{8'h00, 3'b011},
      '{8'h93, 3'b011}, '{8'h00, 3'b011}, '{8'h10, 3'b011}, '{8'h00, 3'b011},
      '{8'h44, 3'b011}, '{8'h00, 3'b011}, '{8'h00, 3'b111},
      '{8'h44, 3'b011}, '{8'h01, 3'b011}, '{8'h02, 3'b111},
      '{8'h49, 3'b011}, '{8'h01, 3'b011}, '{8'h00, 3'b011},
      '{8'hAA, 3'b011}, '{8'hBB, 3'b011}, '{8'hCC, 3'b011}, '{8'hDD, 3'b011},
      '{8'h44, 3'b011}, '{8'h01, 3'b011}, '{8'h00, 3'b011},
      '{8'h11, 3'b011}, '{8'h22, 3'b011}, '{8'h33, 3'b011}, '{8'h44, 3'b011},
      '{8'h47, 3'b000}, '{8'h00, 3'b000}, '{8'h49, 3'b000},
      '{8'h52, 3'b011}, '{8'h58, 3'b011}
    };
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_load_active", load_active, 1);
    check("rst_err", err, 0);
    #2 rst = 1'b1;
    #1 check("first_cycle_ready", in_ready, 0);
    @(negedge clk);
    check("ready_after_first", in_ready, 1);
    ready_chk = 1;
    // main protocol table: flags are {err, core_rst, load_active} after each accepted byte
    for (int i = 0; i < NV; i++) begin
      send(vt[i].b);
      check($sformatf("vec%0d_flags", i), {err, core_rst, load_active}, vt[i].f);
    end
    pause(3);
    exp_q.push_back('{1'b0, 9'd0, 32'h00000013});
    exp_q.push_back('{1'b0, 9'd1, 32'h00100093});
    exp_q.push_back('{1'b0, 9'd0, 32'hDDCCBBAA});
    exp_q.push_back('{1'b1, 9'd0, 32'h44332211});
    check_log();
    // full-size dmem load, byte value = index mod 256
    send(8'h44);
    send(8'h00);
    send(8'h02);
    for (int i = 0; i < 2048; i++) send(8'(i));
    pause(6);
    for (int w = 0; w < 512; w++)
      exp_q.push_back('{1'b1, 9'(w), {8'(4 * w + 3), 8'(4 * w + 2), 8'(4 * w + 1), 8'(4 * w)}});
    check_log();
    check("big_err", err, 0);
    check("big_ready_idle", in_ready, 1);
    // continuous valid through a 3-word frame
    send(8'h49);
    send(8'h03);
    send(8'h00);
    for (int i = 1; i <= 12; i++) send(8'(i));
    pause(4);
    exp_q.push_back('{1'b0, 9'd0, 32'h04030201});
    exp_q.push_back('{1'b0, 9'd1, 32'h08070605});
    exp_q.push_back('{1'b0, 9'd2, 32'h0C0B0A09});
    check_log();
    // reset mid-frame after 2 bytes of word 1
    send(8'h47);
    check("go_core_rst", core_rst, 0);
    send(8'h52);
    send(8'h49);
    send(8'h02);
    send(8'h00);
    for (int i = 0; i < 6; i++) send(8'(8'h21 + i));
    in_valid = 1'b0;
    ready_chk = 0;
    #2 rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_core_rst", core_rst, 1);
    check("midrst_load_active", load_active, 1);
    check("midrst_err", err, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("midrst_first_cycle_ready", in_ready, 0);
    @(negedge clk);
    check("midrst_ready_after", in_ready, 1);
    ready_chk = 1;
    exp_q.push_back('{1'b0, 9'd0, 32'h24232221});
    check_log();
    send(8'h49);
    send(8'h01);
    send(8'h00);
    for (int i = 0; i < 4; i++) send(8'(8'h31 + i));
    pause(4);
    exp_q.push_back('{1'b0, 9'd0, 32'h34333231});
    check_log();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
